stride_counter: RTL and testbench

//  Parametrised up/down stride counter with bounded range, run-time step, parallel load
//  and wrap or saturate policy. Generalises the fixed odd-number counter.

---
 rtl/stride_counter.sv | 121 ++++++++++++
 tb/tb_stride_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stride_counter.sv
// stride_counter: bounded up/down stride counter used as a sequence/address
// generator. Supports a run-time step, a parallel load (clamped into range)
// and either wrap-to-opposite-bound or saturate-at-bound on a crossing.
//
// Optional feature macro: STRIDE_CNT_WRAPCNT_EN adds wrap_cnt_o, a saturating
// count of wrap events that is cleared by reset and by load.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   en         in   advance one step this cycle
//   dir        in   0 = up, 1 = down
//   step_i     in   stride, sampled on each enabled cycle
//   load       in   parallel load strobe (wins over en)
//   load_val   in   load value, clamped to [LIMIT_LO, LIMIT_HI]
//   cnt_o      out  current count (live register)
//   wrap_o     out  1-cycle pulse: the last update crossed a bound
//   tc_o       out  cnt_o sits on the bound in the current direction
//   wrap_cnt_o out  wrap event count (STRIDE_CNT_WRAPCNT_EN only)
module stride_counter #(
  parameter int WIDTH    = 8,
  parameter int START    = 1,
  parameter int LIMIT_LO = 1,
  parameter int LIMIT_HI = 255,
  parameter int SAT_MODE = 0,
  parameter int WRAP_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             tc_o
`ifdef STRIDE_CNT_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt_o
`endif
);

  // Reject illegal bound/start combinations at elaboration.
  if (!(LIMIT_LO >= 0 && LIMIT_LO <= START && START <= LIMIT_HI &&
        longint'(LIMIT_HI) < (longint'(1) << WIDTH) && WRAP_W >= 1)) begin : g_bad_cfg
    $error("stride_counter: need 0 <= LIMIT_LO <= START <= LIMIT_HI < 2**WIDTH and WRAP_W >= 1");
  end

  localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LIMIT_LO);
  localparam logic [WIDTH-1:0] HI_V    = WIDTH'(LIMIT_HI);
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic             SAT     = (SAT_MODE != 0);

  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    wrap_q, wrap_d;
  logic [WIDTH:0]          nxt_up;
  logic signed [WIDTH:0]   nxt_dn;

  always_comb begin
    // One extra bit so the overflow / underflow is visible before the bound test.
    nxt_up = {1'b0, cnt_q} + {1'b0, step_i};
    nxt_dn = $signed({1'b0, cnt_q}) - $signed({1'b0, step_i});
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      if (load_val < LO_V)      cnt_d = LO_V;
      else if (load_val > HI_V) cnt_d = HI_V;
      else                      cnt_d = load_val;
    end else if (en) begin
      if (!dir) begin
        if (nxt_up <= {1'b0, HI_V}) begin
          cnt_d = nxt_up[WIDTH-1:0];
        end else begin
          wrap_d = 1'b1;
          cnt_d  = SAT ? HI_V : LO_V;
        end
      end else begin
        if (nxt_dn >= $signed({1'b0, LO_V})) begin
          cnt_d = nxt_dn[WIDTH-1:0];
        end else begin
          wrap_d = 1'b1;
          cnt_d  = SAT ? LO_V : HI_V;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= START_V;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  assign tc_o   = (cnt_q == (dir ? LO_V : HI_V));

`ifdef STRIDE_CNT_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Counts in step with wrap_o so both show the same event on the same cycle.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (load)                                 wrap_cnt_d = '0;
    else if (wrap_d && (wrap_cnt_q != '1))    wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wrap_cnt_q <= '0;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt_o = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_stride_counter.sv
// Directed bench for stride_counter. Four instances cover the default
// configuration, a saturating narrow range, a 9-bit load-clamp case and a
// tiny-range instance with a 2-bit wrap counter.
module tb_stride_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // u0: defaults
  logic en0, dir0, load0;
  logic [7:0] step0, lv0, cnt0;
  logic wrap0, tc0;
  // u1: LO=10 HI=20 START=10 saturating
  logic en1, dir1, load1;
  logic [7:0] step1, lv1, cnt1;
  logic wrap1, tc1;
  // u2: WIDTH=9, HI=255
  logic en2, dir2, load2;
  logic [8:0] step2, lv2, cnt2;
  logic wrap2, tc2;
  // u3: LO=0 HI=7 START=0 WRAP_W=2
  logic en3, dir3, load3;
  logic [7:0] step3, lv3, cnt3;
  logic wrap3, tc3;
`ifdef STRIDE_CNT_WRAPCNT_EN
  logic [15:0] wc0, wc1, wc2;
  logic [1:0]  wc3;
`endif

  stride_counter u0 (
    .clk(clk), .reset(reset), .en(en0), .dir(dir0), .step_i(step0),
    .load(load0), .load_val(lv0), .cnt_o(cnt0), .wrap_o(wrap0), .tc_o(tc0)
`ifdef STRIDE_CNT_WRAPCNT_EN
    , .wrap_cnt_o(wc0)
`endif
  );

  stride_counter #(.START(10), .LIMIT_LO(10), .LIMIT_HI(20), .SAT_MODE(1)) u1 (
    .clk(clk), .reset(reset), .en(en1), .dir(dir1), .step_i(step1),
    .load(load1), .load_val(lv1), .cnt_o(cnt1), .wrap_o(wrap1), .tc_o(tc1)
`ifdef STRIDE_CNT_WRAPCNT_EN
    , .wrap_cnt_o(wc1)
`endif
  );

  stride_counter #(.WIDTH(9), .LIMIT_HI(255)) u2 (
    .clk(clk), .reset(reset), .en(en2), .dir(dir2), .step_i(step2),
    .load(load2), .load_val(lv2), .cnt_o(cnt2), .wrap_o(wrap2), .tc_o(tc2)
`ifdef STRIDE_CNT_WRAPCNT_EN
    , .wrap_cnt_o(wc2)
`endif
  );

  stride_counter #(.START(0), .LIMIT_LO(0), .LIMIT_HI(7), .WRAP_W(2)) u3 (
    .clk(clk), .reset(reset), .en(en3), .dir(dir3), .step_i(step3),
    .load(load3), .load_val(lv3), .cnt_o(cnt3), .wrap_o(wrap3), .tc_o(tc3)
`ifdef STRIDE_CNT_WRAPCNT_EN
    , .wrap_cnt_o(wc3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {en0, dir0, load0, en1, dir1, load1, en2, dir2, load2, en3, dir3, load3} = '0;
    step0 = '0; lv0 = '0; step1 = '0; lv1 = '0;
    step2 = '0; lv2 = '0; step3 = '0; lv3 = '0;

    // Reset holds START even with en asserted.
    en0 = 1'b1; step0 = 8'd2;
    tick(); tick();
    chk("rst_cnt0", cnt0, 1);
    chk("rst_wrap0", wrap0, 0);
    chk("rst_tc0", tc0, 0);
    chk("rst_cnt1", cnt1, 10);
    chk("rst_cnt3", cnt3, 0);
`ifdef STRIDE_CNT_WRAPCNT_EN
    chk("rst_wc0", wc0, 0);
`endif

    // Odd sequence 1,3,...,255 then wrap to 1.
    reset = 1'b0;
    for (int i = 3; i <= 255; i += 2) begin
      tick();
      chk("odd_cnt", cnt0, i);
      chk("odd_wrap", wrap0, 0);
    end
    chk("odd_tc_at_hi", tc0, 1);
    tick();
    chk("odd_wrap_cnt", cnt0, 1);
    chk("odd_wrap_pulse", wrap0, 1);
    tick();
    chk("odd_after_cnt", cnt0, 3);
    chk("odd_after_wrap", wrap0, 0);

    // Down-count from 9 by 4: 5, 1 (exact bound, no wrap), 255 with wrap.
    en0 = 1'b0; load0 = 1'b1; lv0 = 8'd9;
    tick();
    chk("dn_load", cnt0, 9);
    load0 = 1'b0; en0 = 1'b1; dir0 = 1'b1; step0 = 8'd4;
    tick();
    chk("dn_5", cnt0, 5);
    tick();
    chk("dn_1", cnt0, 1);
    chk("dn_1_wrap", wrap0, 0);
    chk("dn_tc_lo", tc0, 1);
    tick();
    chk("dn_255", cnt0, 255);
    chk("dn_255_wrap", wrap0, 1);
    // step 0 holds with no pulse; en=0 holds.
    step0 = 8'd0;
    tick();
    chk("step0_cnt", cnt0, 255);
    chk("step0_wrap", wrap0, 0);
    en0 = 1'b0; step0 = 8'd4;
    tick();
    chk("hold_cnt", cnt0, 255);

    // Saturating narrow range.
    load1 = 1'b1; lv1 = 8'd18;
    tick();
    chk("sat_load", cnt1, 18);
    chk("sat_load_wrap", wrap1, 0);
    load1 = 1'b0; en1 = 1'b1; step1 = 8'd3;
    tick();
    chk("sat_hi", cnt1, 20);
    chk("sat_hi_wrap", wrap1, 1);
    tick();
    chk("sat_hi2", cnt1, 20);
    chk("sat_hi2_wrap", wrap1, 1);
    dir1 = 1'b1; step1 = 8'd5;
    tick();
    chk("sat_dn15", cnt1, 15);
    chk("sat_dn15_wrap", wrap1, 0);
    tick();
    chk("sat_dn10", cnt1, 10);
    chk("sat_dn10_wrap", wrap1, 0);
    tick();
    chk("sat_lo", cnt1, 10);
    chk("sat_lo_wrap", wrap1, 1);
    en1 = 1'b0; load1 = 1'b1; lv1 = 8'd3;
    tick();
    chk("clamp_lo", cnt1, 10);
    lv1 = 8'd25;
    tick();
    chk("clamp_hi", cnt1, 20);
    load1 = 1'b0;

    // Load beats en; out-of-range value clamps to HI.
    load2 = 1'b1; en2 = 1'b1; step2 = 9'd2; lv2 = 9'd300;
    tick();
    chk("w9_clamp", cnt2, 255);
    chk("w9_clamp_wrap", wrap2, 0);
    load2 = 1'b0;
    tick();
    chk("w9_wrap_cnt", cnt2, 1);
    chk("w9_wrap", wrap2, 1);
    en2 = 1'b0;

    // Five forced wraps on the tiny range.
    en3 = 1'b1; step3 = 8'd8;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("w3_cnt", cnt3, 0);
      chk("w3_wrap", wrap3, 1);
`ifdef STRIDE_CNT_WRAPCNT_EN
      chk("w3_wc", wc3, (i > 3) ? 3 : i);
`endif
    end
    en3 = 1'b0; load3 = 1'b1; lv3 = 8'd4;
    tick();
    chk("w3_load", cnt3, 4);
    chk("w3_load_wrap", wrap3, 0);
`ifdef STRIDE_CNT_WRAPCNT_EN
    chk("w3_load_wc", wc3, 0);
`endif
    load3 = 1'b0; en3 = 1'b1;
    tick();
    chk("w3_prerst_wrap", wrap3, 1);
`ifdef STRIDE_CNT_WRAPCNT_EN
    chk("w3_prerst_wc", wc3, 1);
`endif

    // Reset mid-run overrides load and en.
    en0 = 1'b1; dir0 = 1'b0; load0 = 1'b1; lv0 = 8'd100;
    reset = 1'b1;
    tick();
    chk("mrst_cnt0", cnt0, 1);
    chk("mrst_wrap0", wrap0, 0);
    chk("mrst_cnt1", cnt1, 10);
    chk("mrst_cnt3", cnt3, 0);
    chk("mrst_wrap3", wrap3, 0);
`ifdef STRIDE_CNT_WRAPCNT_EN
    chk("mrst_wc3", wc3, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
